device_bus_endpoint: RTL

- Peripheral-side responder for the shared tri-state device bus. The CPU-side device interface initiates reads (mode=1) and writes (mode=0) on that bus.
- Occupies two consecutive device slots:
  - DATA slot: FIFO data port.
  - STATUS slot: status register.
- Buffers CPU writes in an RX FIFO for the peripheral, and peripheral data in a TX FIFO for CPU reads. Each FIFO has a valid/ready handshake on the peripheral side.

---
 rtl/device_bus_endpoint.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/device_bus_endpoint.sv
// ---------------------------------------------------------------------------
// device_bus_endpoint
//
// Peripheral-side responder on the shared tri-state device bus. It occupies
// two consecutive slots:
//   BASE_ADDR     DATA slot. A CPU write pushes into the RX FIFO. A CPU read
//                 pops the TX FIFO.
//   BASE_ADDR+1   STATUS slot. A CPU read returns the status word and clears
//                 the sticky bits.
//
// Ports
//   clk, reset_n          clock (posedge) and async active-low reset
//   address, enable, mode bus request from the initiator (mode 1 = CPU read)
//   device_data           bidirectional bus data (driven only on CPU reads)
//   rx_data, rx_valid     RX FIFO head and non-empty flag, to the peripheral
//   rx_ready              peripheral accepts rx_data
//   tx_data, tx_valid     peripheral data offered for CPU reads
//   tx_ready              TX FIFO has room
//
// Status word: [0] TX non-empty, [1] RX full, [2] RX overflow (sticky),
//              [3] TX underflow (sticky). The upper bits read as 0.
// ---------------------------------------------------------------------------
module device_bus_endpoint #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int BASE_ADDR  = 0,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  enable,
  input  logic                  mode,
  inout  wire  [DATA_WIDTH-1:0] device_data,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam logic [ADDR_WIDTH-1:0] DATA_ADDR = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] STAT_ADDR = ADDR_WIDTH'(BASE_ADDR + 1);

  // The pointers carry one extra wrap bit. Full means the pointers differ only in that bit.
  function automatic logic ptr_full(input logic [PW-1:0] wr, input logic [PW-1:0] rd);
    ptr_full = (wr[PW-1] != rd[PW-1]) && (wr[PW-2:0] == rd[PW-2:0]);
  endfunction

  // Reset synchronizer: asserts asynchronously and releases on a clock edge.
  logic rst_meta_q, rst_sync_q;

  // Two-flop release of the internal reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  // rst_sync_q drops together with reset_n, so gating with it also releases the bus at once.
  logic active_s;
  assign active_s = rst_sync_q;

  // FIFO state
  logic [DATA_WIDTH-1:0] rx_mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] tx_mem_q [DEPTH];
  logic [PW-1:0] rx_wr_q, rx_rd_q, tx_wr_q, tx_rd_q;
  logic ovf_q, unf_q;

  logic rx_empty_s, rx_full_s, tx_empty_s, tx_full_s;
  assign rx_empty_s = (rx_wr_q == rx_rd_q);
  assign tx_empty_s = (tx_wr_q == tx_rd_q);
  assign rx_full_s  = ptr_full(rx_wr_q, rx_rd_q);
  assign tx_full_s  = ptr_full(tx_wr_q, tx_rd_q);

  assign rx_valid = !rx_empty_s;
  assign tx_ready = !tx_full_s;
  assign rx_data  = rx_mem_q[rx_rd_q[PW-2:0]];

  // Address decode and transfer qualification
  logic hit_data_s, hit_stat_s;
  logic cpu_wr_s, cpu_rd_s, stat_rd_s;
  logic rx_pop_s, rx_push_s, ovf_set_s;
  logic tx_pop_s, tx_push_s, unf_set_s;

  assign hit_data_s = enable && (address == DATA_ADDR);
  assign hit_stat_s = enable && (address == STAT_ADDR);
  assign cpu_wr_s   = active_s && hit_data_s && !mode;
  assign cpu_rd_s   = active_s && hit_data_s && mode;
  assign stat_rd_s  = active_s && hit_stat_s && mode;

  // A peripheral pop in the same cycle frees the slot, so a write into a full RX FIFO still lands.
  assign rx_pop_s  = active_s && !rx_empty_s && rx_ready;
  assign rx_push_s = cpu_wr_s && (!rx_full_s || rx_pop_s);
  assign ovf_set_s = cpu_wr_s && rx_full_s && !rx_pop_s;

  // TX acceptance looks only at the registered fullness. A CPU pop in the same cycle does not free a slot.
  assign tx_push_s = active_s && tx_valid && !tx_full_s;
  assign tx_pop_s  = cpu_rd_s && !tx_empty_s;
  assign unf_set_s = cpu_rd_s && tx_empty_s;

  logic [DATA_WIDTH-1:0] status_s;
  assign status_s = {{(DATA_WIDTH-4){1'b0}}, unf_q, ovf_q, rx_full_s, !tx_empty_s};

  // Select the read data returned for the addressed slot
  logic [DATA_WIDTH-1:0] drive_val_s;
  logic                  drive_en_s;
  always_comb begin
    drive_val_s = {DATA_WIDTH{1'b0}};
    drive_en_s  = 1'b0;
    case ({hit_data_s, hit_stat_s})
      2'b10: begin
        drive_en_s  = active_s && mode;
        if (tx_empty_s) begin
          drive_val_s = {DATA_WIDTH{1'b0}};
        end else begin
          drive_val_s = tx_mem_q[tx_rd_q[PW-2:0]];
        end
      end
      2'b01: begin
        drive_en_s  = active_s && mode;
        drive_val_s = status_s;
      end
      default: begin
        drive_en_s  = 1'b0;
        drive_val_s = {DATA_WIDTH{1'b0}};
      end
    endcase
  end

  assign device_data = drive_en_s ? drive_val_s : {DATA_WIDTH{1'bz}};

  // RX FIFO: CPU writes in, peripheral pops out
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_wr_q <= {PW{1'b0}};
      rx_rd_q <= {PW{1'b0}};
      for (int i = 0; i < DEPTH; i++) rx_mem_q[i] <= {DATA_WIDTH{1'b0}};
    end else if (!active_s) begin
      rx_wr_q <= {PW{1'b0}};
      rx_rd_q <= {PW{1'b0}};
      for (int i = 0; i < DEPTH; i++) rx_mem_q[i] <= {DATA_WIDTH{1'b0}};
    end else begin
      if (rx_push_s) begin
        rx_mem_q[rx_wr_q[PW-2:0]] <= device_data;
        rx_wr_q <= rx_wr_q + PW'(1);
      end
      if (rx_pop_s) begin
        rx_rd_q <= rx_rd_q + PW'(1);
      end
    end
  end

  // TX FIFO: peripheral pushes in, CPU reads out
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_wr_q <= {PW{1'b0}};
      tx_rd_q <= {PW{1'b0}};
      for (int i = 0; i < DEPTH; i++) tx_mem_q[i] <= {DATA_WIDTH{1'b0}};
    end else if (!active_s) begin
      tx_wr_q <= {PW{1'b0}};
      tx_rd_q <= {PW{1'b0}};
      for (int i = 0; i < DEPTH; i++) tx_mem_q[i] <= {DATA_WIDTH{1'b0}};
    end else begin
      if (tx_push_s) begin
        tx_mem_q[tx_wr_q[PW-2:0]] <= tx_data;
        tx_wr_q <= tx_wr_q + PW'(1);
      end
      if (tx_pop_s) begin
        tx_rd_q <= tx_rd_q + PW'(1);
      end
    end
  end

  // Sticky error flags. Set and clear come from different slots, so they never coincide.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (!active_s) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (ovf_set_s) begin
        ovf_q <= 1'b1;
      end else if (stat_rd_s) begin
        ovf_q <= 1'b0;
      end
      if (unf_set_s) begin
        unf_q <= 1'b1;
      end else if (stat_rd_s) begin
        unf_q <= 1'b0;
      end
    end
  end

endmodule
